mini_src_control_unit: RTL and testbench
========================================

Name: mini_src_control_unit

Overview:
- Hardwired Moore-style control FSM that sequences the single-bus datapath.
- It drives every register-in/out strobe, the memory Read/Write strobes, the select/encode (Gra/Grb/Grc) lines and the ALU operation.
- Each instruction runs through the fetch (T0–T2) and execute (T3–T7) steps.
- It replaces the hand-scripted strobe sequences used in datapath benches.

Parameters:
- MEM_WAIT_MAX, 15: maximum cycles a memory step waits for Mem_ready before a fault (1..255).

Ports:
- Clock  in  1  system clock; all state changes on posedge.
- Reset  in  1  asynchronous, active-low reset.
- IR  in  32  instruction register contents from the datapath; opcode = IR[31:27].
- Mem_ready  in  1  memory handshake; high when the current Read/Write completes this cycle.
- PCout  out  1  PC drives bus.
- MARin  out  1  load MAR.
- IncPC  out  1  ALU computes bus+1 into Z.
- Zin  out  1  load Z.
- ZLOout  out  1  Z low word drives bus.
- PCin  out  1  load PC.
- Read  out  1  memory read; also MDR mux selects Mdatain.
- Write  out  1  memory write of MDR to [MAR].
- MDRin  out  1  load MDR (from Mdatain if Read=1, else from bus).
- MDRout  out  1  MDR drives bus.
- IRin  out  1  load IR.
- Gra  out  1  select register field Ra (IR[26:23]).
- Grb  out  1  select register field Rb (IR[22:19]).
- Grc  out  1  select register field Rc (IR[18:15]).
- Rin  out  1  selected register loads from bus.
- Rout  out  1  selected register drives bus.
- BAout  out  1  selected register drives bus, R0 reads as 0.
- Yin  out  1  load Y.
- Cout  out  1  sign-extended C (IR[18:0]) drives bus.
- ALU_op  out  5  ALU operation code; same encoding as opcode.
- Run  out  1  high while executing; low in reset and HALT.
- Fault  out  1  sticky; memory handshake timeout.

Behaviour:
- States: RST, T0, T1, T2, T3, T4, T5, T6, T7, HALT. Encode as a 4-bit register.
- Reset (Reset=0, asynchronous): state=RST, wait counter=0, Fault=0.
  - All outputs are 0 while in RST; this also applies mid-instruction.
  - After reset release, RST goes to T0 on the next posedge.
- Outputs are pure decodes of state, opcode and Mem_ready. Each strobe is asserted for the whole cycle and the datapath captures on the posedge that ends it.
- Default outputs are 0 and ALU_op=5'b00011 (ADD) unless a step listed below says otherwise.
- Fetch sequence:
  - T0: PCout, MARin, IncPC, Zin.
  - T1: ZLOout, PCin, Read, MDRin.
  - T2: MDRout, IRin.
- Opcodes (decoded in T3 onward): ld=00000, ldi=00001, st=00010, add=00011, sub=00100, and=00101, or=00110, addi=01100, nop=11010, halt=11011. Any other opcode behaves as nop.
- ld:
  - T3: Grb, BAout, Yin.
  - T4: Cout, Zin, ALU_op=ADD.
  - T5: ZLOout, MARin.
  - T6: Read, MDRin.
  - T7: MDRout, Gra, Rin.
  - Then T0.
- ldi: T3/T4 as ld; T5: ZLOout, Gra, Rin; then T0.
- st:
  - T3/T4/T5 as ld.
  - T6: Gra, Rout, MDRin (Read=0).
  - T7: Write.
  - Then T0.
- R-type (add/sub/and/or):
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, Zin, ALU_op=IR[31:27].
  - T5: ZLOout, Gra, Rin.
  - Then T0.
- addi:
  - T3: Grb, Rout, Yin.
  - T4: Cout, Zin, ALU_op=ADD.
  - T5: ZLOout, Gra, Rin.
  - Then T0.
- nop: T3 goes to T0 with no strobes asserted.
- halt: T3 goes to HALT. HALT holds all strobes at 0 and Run=0 until reset.
- Memory steps are T1 (fetch), T6 (ld) and T7 (st).
  - Strobes stay asserted and the state holds while Mem_ready=0.
  - The state advances on the posedge where Mem_ready=1.
  - On a repeated cycle, the PCin re-load in T1 is harmless because Z is unchanged.
- Wait counter:
  - Clears on entry to each memory step.
  - Increments each cycle that Mem_ready=0.
  - When the count reaches MEM_WAIT_MAX with Mem_ready still 0: go to HALT and set Fault=1 (sticky until reset).
- Mem_ready is ignored outside the memory steps.
- Latency with Mem_ready tied high:
  - ld: 8 cycles; st: 8.
  - ldi, R-type, addi: 6.
  - nop: 4.

Test Plan:
- Reset low mid-T4 of an add → all outputs 0 immediately (asynchronous). Release → T0 on the next edge with PCout=MARin=IncPC=Zin=1.
- Mem_ready=1, IR=ld R1,0x5(R2) (0x00900005) → strobe sequence exactly as the ld steps in order, 8 cycles, Run=1 throughout.
- Mem_ready=1, IR=and R1,R2,R3 (0x28918000) → T4 asserts Grc=Rout=Zin=1 with ALU_op=00101; T5 asserts Gra=Rin=ZLOout=1; next state T0 after 6 cycles.
- IR=st with Mem_ready held 0 for 3 cycles in T7 → Write stays high for 4 cycles, then T0. Fault stays 0.
- Mem_ready held 0 during T1 with MEM_WAIT_MAX=15 → 15 wait cycles, then HALT, Fault=1, Run=0. Remains until Reset=0.
- IR opcode 11011 → T3 goes to HALT, Run=0, Fault=0. Opcode 11111 → acts as nop and returns to T0 after 4 cycles.

Source files
------------

// File: rtl/mini_src_control_unit_if.sv
// Control bundle between the hardwired control unit and the single-bus
// datapath: instruction/handshake inputs plus every strobe the unit drives.
interface mini_src_control_unit_if;
    logic [31:0] IR;
    logic        Mem_ready;
    logic        PCout;
    logic        MARin;
    logic        IncPC;
    logic        Zin;
    logic        ZLOout;
    logic        PCin;
    logic        Read;
    logic        Write;
    logic        MDRin;
    logic        MDRout;
    logic        IRin;
    logic        Gra;
    logic        Grb;
    logic        Grc;
    logic        Rin;
    logic        Rout;
    logic        BAout;
    logic        Yin;
    logic        Cout;
    logic [4:0]  ALU_op;
    logic        Run;
    logic        Fault;

    // Control unit side: consumes IR/Mem_ready, drives all strobes.
    modport master (
        input  IR, Mem_ready,
        output PCout, MARin, IncPC, Zin, ZLOout, PCin, Read, Write, MDRin,
               MDRout, IRin, Gra, Grb, Grc, Rin, Rout, BAout, Yin, Cout,
               ALU_op, Run, Fault
    );

    // Datapath side: supplies IR/Mem_ready, obeys the strobes.
    modport slave (
        output IR, Mem_ready,
        input  PCout, MARin, IncPC, Zin, ZLOout, PCin, Read, Write, MDRin,
               MDRout, IRin, Gra, Grb, Grc, Rin, Rout, BAout, Yin, Cout,
               ALU_op, Run, Fault
    );
endinterface

// File: rtl/mini_src_control_unit.sv
// Hardwired Moore control unit for the single-bus datapath.
// Steps through fetch (T0-T2) and execute (T3-T7); memory steps stall on
// Mem_ready and a stall that lasts MEM_WAIT_MAX cycles parks the unit in HALT
// with a sticky Fault.
module mini_src_control_unit #(
    parameter int unsigned MEM_WAIT_MAX = 15
) (
    input  logic                           Clock,
    input  logic                           Reset,
    mini_src_control_unit_if.master        bus
);

    typedef enum logic [3:0] {
        ST_RST  = 4'd0,
        ST_T0   = 4'd1,
        ST_T1   = 4'd2,
        ST_T2   = 4'd3,
        ST_T3   = 4'd4,
        ST_T4   = 4'd5,
        ST_T5   = 4'd6,
        ST_T6   = 4'd7,
        ST_T7   = 4'd8,
        ST_HALT = 4'd9
    } state_e;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [7:0] WAIT_LIMIT = 8'(MEM_WAIT_MAX);

    // ld/ldi/st form an effective address from BAout(Rb) + C.
    function automatic logic is_addr_class(input logic [4:0] op);
        return (op == OP_LD) || (op == OP_LDI) || (op == OP_ST);
    endfunction

    // Register-register ALU instructions; ALU_op comes straight from opcode.
    function automatic logic is_rtype(input logic [4:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
    endfunction

    // Every opcode that does real work beyond T3 (everything else is nop/halt).
    function automatic logic has_execute(input logic [4:0] op);
        return is_addr_class(op) || is_rtype(op) || (op == OP_ADDI);
    endfunction

    state_e     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic [7:0] wait_inc_s;
    logic       fault_q, fault_d;
    logic [4:0] opcode_s;
    logic       mem_step_s;

    assign opcode_s   = bus.IR[31:27];
    assign wait_inc_s = wait_cnt_q + 8'd1;

    // Next-state, wait counter and fault logic, including memory stalls.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = 8'd0;
        fault_d    = fault_q;
        mem_step_s = (state_q == ST_T1) ||
                     ((state_q == ST_T6) && (opcode_s == OP_LD)) ||
                     ((state_q == ST_T7) && (opcode_s == OP_ST));

        case (state_q)
            ST_RST:  state_d = ST_T0;
            ST_T0:   state_d = ST_T1;
            ST_T1:   state_d = ST_T2;
            ST_T2:   state_d = ST_T3;
            ST_T3: begin
                if (opcode_s == OP_HALT) begin
                    state_d = ST_HALT;
                end else if (has_execute(opcode_s)) begin
                    state_d = ST_T4;
                end else begin
                    state_d = ST_T0;
                end
            end
            ST_T4:   state_d = ST_T5;
            ST_T5: begin
                if ((opcode_s == OP_LD) || (opcode_s == OP_ST)) begin
                    state_d = ST_T6;
                end else begin
                    state_d = ST_T0;
                end
            end
            ST_T6: begin
                if ((opcode_s == OP_LD) || (opcode_s == OP_ST)) begin
                    state_d = ST_T7;
                end else begin
                    state_d = ST_T0;
                end
            end
            ST_T7:   state_d = ST_T0;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_RST;
        endcase

        // A memory step holds until Mem_ready; too long a stall is a fault.
        if (mem_step_s && !bus.Mem_ready) begin
            wait_cnt_d = wait_inc_s;
            if (wait_inc_s == WAIT_LIMIT) begin
                state_d = ST_HALT;
                fault_d = 1'b1;
            end else begin
                state_d = state_q;
            end
        end else begin
            wait_cnt_d = 8'd0;
        end
    end

    // State, wait counter and sticky fault registers.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q    <= ST_RST;
            wait_cnt_q <= 8'd0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            fault_q    <= fault_d;
        end
    end

    // Moore decode of strobes from the current step and opcode.
    always_comb begin
        bus.PCout  = 1'b0;
        bus.MARin  = 1'b0;
        bus.IncPC  = 1'b0;
        bus.Zin    = 1'b0;
        bus.ZLOout = 1'b0;
        bus.PCin   = 1'b0;
        bus.Read   = 1'b0;
        bus.Write  = 1'b0;
        bus.MDRin  = 1'b0;
        bus.MDRout = 1'b0;
        bus.IRin   = 1'b0;
        bus.Gra    = 1'b0;
        bus.Grb    = 1'b0;
        bus.Grc    = 1'b0;
        bus.Rin    = 1'b0;
        bus.Rout   = 1'b0;
        bus.BAout  = 1'b0;
        bus.Yin    = 1'b0;
        bus.Cout   = 1'b0;
        bus.ALU_op = OP_ADD;
        bus.Run    = 1'b0;
        bus.Fault  = fault_q;

        case (state_q)
            ST_RST: begin
                bus.ALU_op = 5'b00000;
            end
            ST_T0: begin
                bus.Run   = 1'b1;
                bus.PCout = 1'b1;
                bus.MARin = 1'b1;
                bus.IncPC = 1'b1;
                bus.Zin   = 1'b1;
            end
            ST_T1: begin
                bus.Run    = 1'b1;
                bus.ZLOout = 1'b1;
                bus.PCin   = 1'b1;
                bus.Read   = 1'b1;
                bus.MDRin  = 1'b1;
            end
            ST_T2: begin
                bus.Run    = 1'b1;
                bus.MDRout = 1'b1;
                bus.IRin   = 1'b1;
            end
            ST_T3: begin
                bus.Run = 1'b1;
                if (is_addr_class(opcode_s)) begin
                    bus.Grb   = 1'b1;
                    bus.BAout = 1'b1;
                    bus.Yin   = 1'b1;
                end else if (has_execute(opcode_s)) begin
                    bus.Grb  = 1'b1;
                    bus.Rout = 1'b1;
                    bus.Yin  = 1'b1;
                end else begin
                    bus.Yin = 1'b0;
                end
            end
            ST_T4: begin
                bus.Run = 1'b1;
                bus.Zin = 1'b1;
                if (is_rtype(opcode_s)) begin
                    bus.Grc    = 1'b1;
                    bus.Rout   = 1'b1;
                    bus.ALU_op = opcode_s;
                end else begin
                    bus.Cout = 1'b1;
                end
            end
            ST_T5: begin
                bus.Run    = 1'b1;
                bus.ZLOout = 1'b1;
                if ((opcode_s == OP_LD) || (opcode_s == OP_ST)) begin
                    bus.MARin = 1'b1;
                end else begin
                    bus.Gra = 1'b1;
                    bus.Rin = 1'b1;
                end
            end
            ST_T6: begin
                bus.Run   = 1'b1;
                bus.MDRin = 1'b1;
                if (opcode_s == OP_ST) begin
                    bus.Gra  = 1'b1;
                    bus.Rout = 1'b1;
                end else begin
                    bus.Read = 1'b1;
                end
            end
            ST_T7: begin
                bus.Run = 1'b1;
                if (opcode_s == OP_ST) begin
                    bus.Write = 1'b1;
                end else begin
                    bus.MDRout = 1'b1;
                    bus.Gra    = 1'b1;
                    bus.Rin    = 1'b1;
                end
            end
            ST_HALT: begin
                bus.Run = 1'b0;
            end
            default: begin
                bus.Run = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mini_src_control_unit.sv
// Bench for mini_src_control_unit: a step-list model of each instruction
// (expected strobe vector per cycle plus the Mem_ready to drive) is built from
// the instruction rules and played against the DUT cycle by cycle.
module tb_mini_src_control_unit;

    logic Clock;
    logic Reset;

    mini_src_control_unit_if bus_if();

    mini_src_control_unit #(.MEM_WAIT_MAX(15)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus_if)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Strobe bit masks, packed in port order.
    localparam logic [18:0] S_PCOUT  = 19'd1 << 18;
    localparam logic [18:0] S_MARIN  = 19'd1 << 17;
    localparam logic [18:0] S_INCPC  = 19'd1 << 16;
    localparam logic [18:0] S_ZIN    = 19'd1 << 15;
    localparam logic [18:0] S_ZLOOUT = 19'd1 << 14;
    localparam logic [18:0] S_PCIN   = 19'd1 << 13;
    localparam logic [18:0] S_READ   = 19'd1 << 12;
    localparam logic [18:0] S_WRITE  = 19'd1 << 11;
    localparam logic [18:0] S_MDRIN  = 19'd1 << 10;
    localparam logic [18:0] S_MDROUT = 19'd1 << 9;
    localparam logic [18:0] S_IRIN   = 19'd1 << 8;
    localparam logic [18:0] S_GRA    = 19'd1 << 7;
    localparam logic [18:0] S_GRB    = 19'd1 << 6;
    localparam logic [18:0] S_GRC    = 19'd1 << 5;
    localparam logic [18:0] S_RIN    = 19'd1 << 4;
    localparam logic [18:0] S_ROUT   = 19'd1 << 3;
    localparam logic [18:0] S_BAOUT  = 19'd1 << 2;
    localparam logic [18:0] S_YIN    = 19'd1 << 1;
    localparam logic [18:0] S_COUT   = 19'd1 << 0;
    localparam logic [18:0] S_NONE   = 19'd0;

    localparam logic [4:0] ADD = 5'b00011;
    localparam logic [25:0] FULL_MASK = 26'h3FFFFFF;
    localparam logic [25:0] NO_ALU    = 26'h3FFFF83;

    typedef struct {
        logic [25:0] exp;
        logic [25:0] mask;
        logic        mem;
        string       tag;
    } step_t;

    step_t q[$];
    int checks = 0;
    int errors = 0;

    logic [25:0] obs_s;
    assign obs_s = {bus_if.PCout, bus_if.MARin, bus_if.IncPC, bus_if.Zin,
                    bus_if.ZLOout, bus_if.PCin, bus_if.Read, bus_if.Write,
                    bus_if.MDRin, bus_if.MDRout, bus_if.IRin, bus_if.Gra,
                    bus_if.Grb, bus_if.Grc, bus_if.Rin, bus_if.Rout,
                    bus_if.BAout, bus_if.Yin, bus_if.Cout, bus_if.ALU_op,
                    bus_if.Run, bus_if.Fault};

    task automatic check(input string tag, input logic [25:0] exp, input logic [25:0] mask);
        checks++;
        assert ((obs_s & mask) === (exp & mask)) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h mask=%h", tag, obs_s, exp, mask);
        end
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic push(input logic [18:0] s, input logic [4:0] alu, input logic run,
                        input logic fault, input logic mem, input logic chk_alu,
                        input string tag);
        step_t t;
        t.exp  = {s, alu, run, fault};
        t.mask = chk_alu ? FULL_MASK : NO_ALU;
        t.mem  = mem;
        t.tag  = tag;
        q.push_back(t);
    endtask

    // Non-memory step: Mem_ready is don't-care, so drive it randomly.
    task automatic exec_step(input logic [18:0] s, input logic [4:0] alu, input string tag);
        push(s, alu, 1'b1, 1'b0, rbit(), 1'b1, tag);
    endtask

    // Memory step: 'waits' stalled cycles, then the completing cycle.
    task automatic mem_step(input logic [18:0] s, input int waits, input string tag);
        for (int i = 0; i < waits; i++) push(s, ADD, 1'b1, 1'b0, 1'b0, 1'b1, tag);
        push(s, ADD, 1'b1, 1'b0, 1'b1, 1'b1, tag);
    endtask

    task automatic halted(input logic fault, input int n);
        for (int i = 0; i < n; i++) push(S_NONE, ADD, 1'b0, fault, rbit(), 1'b0, "halt");
    endtask

    // Expected cycle list for one instruction starting at T0.
    task automatic model_instr(input logic [31:0] ir, input int wf, input int wm);
        logic [4:0] op;
        op = ir[31:27];
        exec_step(S_PCOUT | S_MARIN | S_INCPC | S_ZIN, ADD, "T0");
        mem_step(S_ZLOOUT | S_PCIN | S_READ | S_MDRIN, wf, "T1");
        exec_step(S_MDROUT | S_IRIN, ADD, "T2");
        case (op)
            5'b00000, 5'b00001, 5'b00010: begin
                exec_step(S_GRB | S_BAOUT | S_YIN, ADD, "T3addr");
                exec_step(S_COUT | S_ZIN, ADD, "T4addr");
                if (op == 5'b00001) begin
                    exec_step(S_ZLOOUT | S_GRA | S_RIN, ADD, "T5ldi");
                end else begin
                    exec_step(S_ZLOOUT | S_MARIN, ADD, "T5mar");
                    if (op == 5'b00000) begin
                        mem_step(S_READ | S_MDRIN, wm, "T6ld");
                        exec_step(S_MDROUT | S_GRA | S_RIN, ADD, "T7ld");
                    end else begin
                        exec_step(S_GRA | S_ROUT | S_MDRIN, ADD, "T6st");
                        mem_step(S_WRITE, wm, "T7st");
                    end
                end
            end
            5'b00011, 5'b00100, 5'b00101, 5'b00110: begin
                exec_step(S_GRB | S_ROUT | S_YIN, ADD, "T3r");
                exec_step(S_GRC | S_ROUT | S_ZIN, op, "T4r");
                exec_step(S_ZLOOUT | S_GRA | S_RIN, ADD, "T5r");
            end
            5'b01100: begin
                exec_step(S_GRB | S_ROUT | S_YIN, ADD, "T3addi");
                exec_step(S_COUT | S_ZIN, ADD, "T4addi");
                exec_step(S_ZLOOUT | S_GRA | S_RIN, ADD, "T5addi");
            end
            5'b11011: begin
                exec_step(S_NONE, ADD, "T3halt");
                halted(1'b0, 3);
            end
            default: exec_step(S_NONE, ADD, "T3nop");
        endcase
    endtask

    // Play the queued steps; called just after a rising edge.
    task automatic run_q(input logic [31:0] ir);
        step_t s;
        bus_if.IR = ir;
        while (q.size() > 0) begin
            s = q.pop_front();
            bus_if.Mem_ready = s.mem;
            @(negedge Clock);
            check(s.tag, s.exp, s.mask);
            @(posedge Clock);
            #1;
        end
    endtask

    // Assert reset asynchronously, check outputs clear, release into T0.
    task automatic do_reset(input string tag);
        Reset = 1'b0;
        #1;
        check(tag, 26'd0, FULL_MASK);
        @(posedge Clock);
        #1;
        Reset = 1'b1;
        @(posedge Clock);
        #1;
    endtask

    function automatic int pick_wait();
        if ($urandom_range(0, 7) == 0) begin
            return 14;
        end else begin
            return int'($urandom_range(0, 4));
        end
    endfunction

    logic [4:0] ops [12] = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101,
                             5'b00110, 5'b01100, 5'b11010, 5'b11111, 5'b00111, 5'b10101};

    initial begin
        logic [31:0] ir;
        Reset = 1'b0;
        bus_if.IR = 32'd0;
        bus_if.Mem_ready = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        check("reset_idle", 26'd0, FULL_MASK);
        Reset = 1'b1;
        @(posedge Clock);
        #1;

        // Directed: ld R1,0x5(R2), and R1,R2,R3, st with 3 stalls in T7, nop 11111.
        model_instr(32'h00900005, 0, 0);
        run_q(32'h00900005);
        model_instr(32'h28918000, 0, 0);
        run_q(32'h28918000);
        model_instr(32'h10800010, 0, 3);
        run_q(32'h10800010);
        model_instr(32'hF8000000, 0, 0);
        run_q(32'hF8000000);

        // Random instruction stream with random memory stalls (up to 14).
        for (int n = 0; n < 30; n++) begin
            ir = {ops[$urandom_range(0, 11)], 27'($urandom)};
            model_instr(ir, pick_wait(), pick_wait());
            run_q(ir);
        end

        // Reset asserted in the middle of T4 of an add.
        model_instr(32'h18918000, 0, 0);
        void'(q.pop_back());
        void'(q.pop_back());
        run_q(32'h18918000);
        check("T4_before_rst", {S_GRC | S_ROUT | S_ZIN, ADD, 1'b1, 1'b0}, FULL_MASK);
        #2;
        do_reset("async_rst_midT4");
        model_instr(32'h60900007, 0, 0);
        run_q(32'h60900007);

        // Fetch stall of 15 cycles: timeout into HALT with sticky Fault.
        exec_step(S_PCOUT | S_MARIN | S_INCPC | S_ZIN, ADD, "T0to");
        for (int i = 0; i < 15; i++) push(S_ZLOOUT | S_PCIN | S_READ | S_MDRIN, ADD, 1'b1, 1'b0, 1'b0, 1'b1, "T1stall");
        halted(1'b1, 4);
        run_q(32'h18918000);
        do_reset("rst_after_fault");

        // halt opcode parks without fault.
        model_instr(32'hD8000000, 0, 0);
        run_q(32'hD8000000);
        do_reset("rst_after_halt");

        model_instr(32'h08900003, 1, 0);
        run_q(32'h08900003);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
